// File: rtl/store_lane_pkg.sv
// Shared constants, FSM state encoding and lane-geometry helpers for the
// store lane unit.
package store_lane_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    function automatic int nb_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/store_lane_unit_lane_mask_gen.sv
// Byte-enable and write-data steering for one beat of a store; beat selects
// the low (first) or high (spill-over) half of the shifted access.
module lane_mask_gen
    import store_lane_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 32,
    localparam int NB     = nb_of(DATA_W),
    localparam int OW     = off_w_of(DATA_W)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] data,
    input  logic              beat,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata,
    output logic              split
);

    logic [OW-1:0]       off;
    logic [OW+1:0]       nbytes;
    logic [OW+1:0]       end_pos;
    logic [DATA_W-1:0]   data_m;
    logic [2*NB-1:0]     be_wide;
    logic [2*DATA_W-1:0] data_wide;
    logic [ADDR_W-1:0]   base;

    always_comb begin
        off     = addr[OW-1:0];
        nbytes  = (OW+2)'(1) << size;
        end_pos = {2'b00, off} + nbytes;
        split   = end_pos > (OW+2)'(NB);

        // Only the low N bytes of the right-aligned data are meaningful.
        data_m = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes)) begin
                data_m[8*i +: 8] = data[8*i +: 8];
            end
        end

        // Shift into a double-width window; the upper half is the second beat.
        be_wide   = (((2*NB)'(1) << nbytes) - (2*NB)'(1)) << off;
        data_wide = {{DATA_W{1'b0}}, data_m} << {off, 3'b000};
        base      = {addr[ADDR_W-1:OW], {OW{1'b0}}};

        if (beat) begin
            beat_addr = base + ADDR_W'(NB);
            be        = be_wide[2*NB-1:NB];
            wdata     = data_wide[2*DATA_W-1:DATA_W];
        end else begin
            beat_addr = base;
            be        = be_wide[NB-1:0];
            wdata     = data_wide[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/store_lane_unit.sv
// Store lane unit: accepts one store at a time and issues one or two
// registered, lane-steered bus write beats, or a one-cycle error pulse.
module store_lane_unit
    import store_lane_pkg::*;
#(
    parameter int  DATA_W        = 32,
    parameter int  ADDR_W        = 32,
    parameter int  MISALIGN_MODE = 1,
    localparam int NB            = nb_of(DATA_W),
    localparam int OW            = off_w_of(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    input  logic [DATA_W-1:0] in_data,
    output logic              bus_req,
    input  logic              bus_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [NB-1:0]     bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic              busy
);

    // Handshakes: a request transfers on a rising edge with in_valid && in_ready;
    // a bus beat completes on a rising edge with bus_req && bus_ack, and the
    // beat's address/enables/data are held unchanged until that edge.

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              split_q, split_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0]     bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [ADDR_W-1:0] g_addr;
    logic [1:0]        g_size;
    logic [DATA_W-1:0] g_data;
    logic              g_beat;
    logic [ADDR_W-1:0] g_beat_addr;
    logic [NB-1:0]     g_be;
    logic [DATA_W-1:0] g_wdata;
    logic              g_split;

    logic              is_idle;
    logic [OW+1:0]     in_mask;
    logic              misaligned;
    logic              size_illegal;
    logic              req_err;

    assign is_idle = (state_q == ST_IDLE);

    // In IDLE the generator looks at the incoming request (first beat);
    // afterwards it works on the latched request to produce the second beat.
    always_comb begin
        g_addr = is_idle ? in_addr : addr_q;
        g_size = is_idle ? in_size : size_q;
        g_data = is_idle ? in_data : data_q;
        g_beat = !is_idle;
    end

    lane_mask_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lane_mask_gen (
        .addr      (g_addr),
        .size      (g_size),
        .data      (g_data),
        .beat      (g_beat),
        .beat_addr (g_beat_addr),
        .be        (g_be),
        .wdata     (g_wdata),
        .split     (g_split)
    );

    always_comb begin
        in_mask      = ((OW+2)'(1) << in_size) - (OW+2)'(1);
        misaligned   = (({2'b00, in_addr[OW-1:0]} & in_mask) != '0);
        size_illegal = (in_size == SZ_DWORD) && (DATA_W < 64);
        req_err      = size_illegal || ((MISALIGN_MODE == 0) && misaligned);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        data_d      = data_q;
        split_d     = split_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d = in_addr;
                    size_d = in_size;
                    data_d = in_data;
                    if (req_err) begin
                        state_d    = ST_ERR;
                        err_addr_d = in_addr;
                    end else begin
                        state_d     = ST_BEAT0;
                        split_d     = g_split;
                        bus_req_d   = 1'b1;
                        bus_addr_d  = g_beat_addr;
                        bus_be_d    = g_be;
                        bus_wdata_d = g_wdata;
                    end
                end
            end
            ST_BEAT0: begin
                if (bus_ack) begin
                    if (split_q) begin
                        state_d     = ST_BEAT1;
                        bus_addr_d  = g_beat_addr;
                        bus_be_d    = g_be;
                        bus_wdata_d = g_wdata;
                    end else begin
                        state_d     = ST_IDLE;
                        bus_req_d   = 1'b0;
                        bus_addr_d  = '0;
                        bus_be_d    = '0;
                        bus_wdata_d = '0;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            data_q      <= '0;
            split_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            split_q     <= split_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign in_ready  = reset_n && is_idle;
    assign busy      = !is_idle;
    assign err_valid = (state_q == ST_ERR);
    assign err_addr  = err_addr_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_store_lane_unit.sv
// Self-checking bench for store_lane_unit (DATA_W=32): directed vector table,
// hand-written corner sequences and random stores against a byte-level model.
module tb_store_lane_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int BW = AW + NB + DW;

    logic          clk;
    logic          reset_n;
    logic          in_valid, in_valid_s;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_size;
    logic [DW-1:0] in_data;
    logic          bus_ack;

    logic          in_ready, bus_req, err_valid, busy;
    logic [AW-1:0] bus_addr, err_addr;
    logic [NB-1:0] bus_be;
    logic [DW-1:0] bus_wdata;

    logic          in_ready_s, bus_req_s, err_valid_s, busy_s;
    logic [AW-1:0] bus_addr_s, err_addr_s;
    logic [NB-1:0] bus_be_s;
    logic [DW-1:0] bus_wdata_s;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] exp_q[$];

    store_lane_unit #(.DATA_W(DW), .ADDR_W(AW), .MISALIGN_MODE(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_size(in_size), .in_data(in_data),
        .bus_req(bus_req), .bus_ack(bus_ack), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .err_valid(err_valid), .err_addr(err_addr), .busy(busy)
    );

    store_lane_unit #(.DATA_W(DW), .ADDR_W(AW), .MISALIGN_MODE(0)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_addr(in_addr), .in_size(in_size), .in_data(in_data),
        .bus_req(bus_req_s), .bus_ack(bus_ack), .bus_addr(bus_addr_s), .bus_be(bus_be_s),
        .bus_wdata(bus_wdata_s), .err_valid(err_valid_s), .err_addr(err_addr_s), .busy(busy_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: place each of the N bytes at its absolute address,
    // then group bytes by bus line. Pushes the beats it expects into exp_q.
    task automatic model_store(input logic [AW-1:0] a, input logic [1:0] s,
                               input logic [DW-1:0] d, output bit e);
        logic [AW-1:0] line0, ba, rel;
        logic [NB-1:0] be[2];
        logic [DW-1:0] wd[2];
        int            n, k, lane, nbeats;
        e = (s == 2'd3);
        if (!e) begin
            n      = 1 << s;
            line0  = a - (a % NB);
            be[0]  = '0; be[1] = '0; wd[0] = '0; wd[1] = '0;
            nbeats = 1;
            for (int i = 0; i < n; i++) begin
                ba   = a + AW'(i);
                rel  = ba - line0;
                k    = int'(rel / NB);
                lane = int'(ba % NB);
                be[k][lane] = 1'b1;
                wd[k][8*lane +: 8] = d[8*i +: 8];
                if (k + 1 > nbeats) nbeats = k + 1;
            end
            for (int k2 = 0; k2 < nbeats; k2++)
                exp_q.push_back({line0 + AW'(k2 * NB), be[k2], wd[k2]});
        end
    endtask

    // Driver: present one request, then walk the expected beats, stalling
    // each beat for 'delay' cycles before acknowledging it.
    task automatic run_txn(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d,
                           input int delay, input bit e);
        logic [BW-1:0] beat, held;
        @(negedge clk);
        in_valid = 1'b1; in_addr = a; in_size = s; in_data = d;
        chk("in_ready_idle", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        if (e) begin
            chk("err_valid_on", err_valid, 1'b1);
            chk("err_addr", err_addr, a);
            chk("err_no_req", bus_req, 1'b0);
            @(negedge clk);
            chk("err_valid_off", err_valid, 1'b0);
            chk("err_in_ready", in_ready, 1'b1);
            chk("err_no_req2", bus_req, 1'b0);
        end else begin
            while (exp_q.size() > 0) begin
                beat = exp_q.pop_front();
                chk("bus_req_high", bus_req, 1'b1);
                held = {bus_addr, bus_be, bus_wdata};
                for (int i = 0; i < delay; i++) begin
                    @(negedge clk);
                    chk("stall_hold", {bus_req, bus_addr, bus_be, bus_wdata}, {1'b1, held});
                end
                chk("beat", {bus_addr, bus_be, bus_wdata}, beat);
                bus_ack = 1'b1;
                @(negedge clk);
                bus_ack = 1'b0;
            end
            chk("req_drop", bus_req, 1'b0);
            chk("busy_drop", busy, 1'b0);
            chk("ready_back", in_ready, 1'b1);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic [DW-1:0] data;
        int            delay;
        bit            err;
        int            nb;
        logic [AW-1:0] a0; logic [NB-1:0] be0; logic [DW-1:0] d0;
        logic [AW-1:0] a1; logic [NB-1:0] be1; logic [DW-1:0] d1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit            e;
        logic [AW-1:0] ra;
        logic [1:0]    rs;
        logic [DW-1:0] rd;

        vecs[0] = '{32'h1000, 2'd2, 32'hDEADBEEF, 0, 0, 1, 32'h1000, 4'hF, 32'hDEADBEEF, 0, 0, 0};
        vecs[1] = '{32'h1003, 2'd0, 32'h000000AB, 1, 0, 1, 32'h1000, 4'h8, 32'hAB000000, 0, 0, 0};
        vecs[2] = '{32'h1002, 2'd2, 32'h11223344, 0, 0, 2, 32'h1000, 4'hC, 32'h33440000, 32'h1004, 4'h3, 32'h00001122};
        vecs[3] = '{32'h1003, 2'd1, 32'h0000BEEF, 5, 0, 2, 32'h1000, 4'h8, 32'hEF000000, 32'h1004, 4'h1, 32'h000000BE};
        vecs[4] = '{32'hFFFFFFFF, 2'd2, 32'hA1B2C3D4, 2, 0, 2, 32'hFFFFFFFC, 4'h8, 32'hD4000000, 32'h0, 4'h7, 32'h00A1B2C3};
        vecs[5] = '{32'h2002, 2'd1, 32'h00005566, 5, 0, 1, 32'h2000, 4'hC, 32'h55660000, 0, 0, 0};
        vecs[6] = '{32'h0000, 2'd0, 32'h0000007F, 0, 0, 1, 32'h0000, 4'h1, 32'h0000007F, 0, 0, 0};
        vecs[7] = '{32'h3000, 2'd3, 32'h12345678, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        reset_n = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0;
        in_addr = '0; in_size = '0; in_data = '0; bus_ack = 1'b0;

        #2;
        chk("rst_outputs", {in_ready, bus_req, bus_addr, bus_be, bus_wdata, err_valid, err_addr, busy}, '0);
        chk("rst_strict", {in_ready_s, bus_req_s, err_valid_s, busy_s}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // directed vector table
        for (int v = 0; v < 8; v++) begin
            if (!vecs[v].err) begin
                exp_q.push_back({vecs[v].a0, vecs[v].be0, vecs[v].d0});
                if (vecs[v].nb == 2) exp_q.push_back({vecs[v].a1, vecs[v].be1, vecs[v].d1});
            end
            run_txn(vecs[v].addr, vecs[v].size, vecs[v].data, vecs[v].delay, vecs[v].err);
        end

        // ack while idle is ignored
        @(negedge clk);
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ack_req", bus_req, 1'b0);
        chk("idle_ack_busy", busy, 1'b0);
        bus_ack = 1'b0;

        // strict mode: misaligned half errors, aligned half issues one beat
        @(negedge clk);
        in_valid_s = 1'b1; in_addr = 32'h2001; in_size = 2'd1; in_data = 32'h00001234;
        chk("s_in_ready", in_ready_s, 1'b1);
        @(negedge clk);
        in_valid_s = 1'b0;
        chk("s_err_valid", err_valid_s, 1'b1);
        chk("s_err_addr", err_addr_s, 32'h2001);
        chk("s_no_req", bus_req_s, 1'b0);
        @(negedge clk);
        chk("s_err_off", err_valid_s, 1'b0);
        chk("s_ready_after", in_ready_s, 1'b1);
        in_valid_s = 1'b1; in_addr = 32'h2002; in_size = 2'd1; in_data = 32'h00005566;
        @(negedge clk);
        in_valid_s = 1'b0;
        chk("s_beat", {bus_req_s, bus_addr_s, bus_be_s, bus_wdata_s}, {1'b1, 32'h2000, 4'hC, 32'h55660000});
        chk("s_main_idle", bus_req, 1'b0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("s_req_drop", bus_req_s, 1'b0);

        // reset during the second beat of a split store
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h1002; in_size = 2'd2; in_data = 32'h11223344;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs_beat0_req", bus_req, 1'b1);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rs_beat1", {bus_req, bus_addr, bus_be}, {1'b1, 32'h1004, 4'h3});
        reset_n = 1'b0;
        #1;
        chk("rs_req_low", bus_req, 1'b0);
        chk("rs_busy_low", busy, 1'b0);
        chk("rs_bus_zero", {bus_addr, bus_be, bus_wdata, in_ready}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rs_ready", in_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("rs_no_beats", bus_req, 1'b0);
        end

        // random stores against the model
        for (int r = 0; r < 60; r++) begin
            rs = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = $urandom;
            if ($urandom_range(0, 9) == 0) ra = 32'hFFFFFFFC | AW'($urandom_range(0, 3));
            rd = $urandom;
            if (rs == 2'd0) rd = rd & 32'h000000FF;
            if (rs == 2'd1) rd = rd & 32'h0000FFFF;
            model_store(ra, rs, rd, e);
            run_txn(ra, rs, rd, $urandom_range(0, 3), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
